// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction memory request/response plus the decode-side valid/ready port.
// The master modport is the queue itself; the slave modport is memory plus decode.
interface fetch_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  imem_request;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_valid;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;

    modport master (
        output imem_request, imem_addr, out_valid, out_instr, out_pc,
        input  imem_valid, imem_data, out_ready
    );

    modport slave (
        input  imem_request, imem_addr, out_valid, out_instr, out_pc,
        output imem_valid, imem_data, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO of {pc, instr} pairs between instruction memory and decode.
// Fetches sequentially while space exists; a redirect discards all buffered entries.
module fetch_queue #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_BYTES = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
    fetch_queue_if.master                bus_io,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = $clog2(DEPTH+1);
    localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [EntryW-1:0]     mem_q [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        // Registered count gates the request, so a same-cycle pop never opens space.
        bus_io.imem_request = !rst_i && !flush_i && (count_q < CntW'(DEPTH));
        bus_io.imem_addr    = fetch_pc_q;
        bus_io.out_valid    = (count_q != '0);
        {bus_io.out_pc, bus_io.out_instr} = mem_q[rd_ptr_q];

        push = bus_io.imem_request && bus_io.imem_valid;
        pop  = bus_io.out_valid && bus_io.out_ready && !flush_i;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_i) begin
            fetch_pc_d = redirect_pc_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= PC_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {fetch_pc_q, bus_io.imem_data};
            end
        end
    end

    assign count_o = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, PC_RESET=0).
// Memory returns a pc-derived instruction word so each pc/instr pairing can be checked.
module tb_fetch_queue;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    fetch_queue #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .INSTR_BYTES(4), .PC_RESET(32'h0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .redirect_pc_i(redirect_pc),
        .bus_io(bus),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pc 0 -> 0x00000013, pc 4 -> 0x00100093, ...
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0000_0013 + (a >> 2) * 32'h0010_0080;
    endfunction

    assign bus.imem_data = instr_of(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; redirect_pc = '0;
        bus.imem_valid = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; redirect_pc = '0;
        bus.imem_valid = 1'b1; bus.out_ready = 1'b0;
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (bus.imem_request !== 1'b0) begin errors++; $display("FAIL reset_request got %0b want 0", bus.imem_request); end
        checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_entry got pc %h instr %h want 0 0", bus.out_pc, bus.out_instr); end
        rst = 1'b0; bus.imem_valid = 1'b0;
        #1;
        checks++; if (bus.imem_request !== 1'b1) begin errors++; $display("FAIL post_reset_request got %0b want 1", bus.imem_request); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_addr got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready = 1'b1; bus.imem_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got v%0b pc %h want v1 pc %h", k, bus.out_valid, bus.out_pc, 32'(4 * k)); end
            checks++; if (bus.out_instr !== instr_of(32'(4 * k))) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, bus.out_instr, instr_of(32'(4 * k))); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
        end
        bus.out_ready = 1'b0; bus.imem_valid = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        do_reset();
        bus.out_ready = 1'b0; bus.imem_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (count !== 3'(k)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", k, count, k); end
        end
        tick(); tick();
        checks++; if (bus.imem_request !== 1'b0) begin errors++; $display("FAIL full_request got %0b want 0", bus.imem_request); end
        checks++; if (bus.imem_addr !== 32'd16 || count !== 3'd4) begin errors++; $display("FAIL full_hold got addr %h count %0d want 10 4", bus.imem_addr, count); end
        checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL full_head got %h want 0", bus.out_pc); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd3 || bus.out_pc !== 32'd4) begin errors++; $display("FAIL pop_one got count %0d pc %h want 3 4", count, bus.out_pc); end
        checks++; if (bus.imem_request !== 1'b1 || bus.imem_addr !== 32'd16) begin errors++; $display("FAIL rerequest got req %0b addr %h want 1 10", bus.imem_request, bus.imem_addr); end
        tick();
        checks++; if (count !== 3'd4 || bus.imem_addr !== 32'd20) begin errors++; $display("FAIL refill got count %0d addr %h want 4 14", count, bus.imem_addr); end
        bus.imem_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (bus.out_pc !== 32'(4 * k) || bus.out_instr !== instr_of(32'(4 * k))) begin errors++; $display("FAIL drain[%0d] got pc %h instr %h want pc %h", k, bus.out_pc, bus.out_instr, 32'(4 * k)); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drained got v%0b count %0d want v0 0", bus.out_valid, count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        bus.out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            bus.imem_valid = 1'b0;
            for (int w = 0; w < 3; w++) begin
                tick();
                checks++; if (bus.imem_request !== 1'b1 || bus.imem_addr !== 32'(4 * f)) begin errors++; $display("FAIL wait_addr[%0d.%0d] got req %0b addr %h want 1 %h", f, w, bus.imem_request, bus.imem_addr, 32'(4 * f)); end
            end
            bus.imem_valid = 1'b1;
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * f) || bus.out_instr !== instr_of(32'(4 * f))) begin errors++; $display("FAIL wait_entry[%0d] got v%0b pc %h instr %h want pc %h", f, bus.out_valid, bus.out_pc, bus.out_instr, 32'(4 * f)); end
        end
        bus.imem_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b0; bus.imem_valid = 1'b1;
        tick(); tick(); tick(); tick();
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0; bus.imem_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got count %0d v%0b want 0 v0", count, bus.out_valid); end
        checks++; if (bus.imem_addr !== 32'h100 || bus.imem_request !== 1'b1) begin errors++; $display("FAIL flush_redirect got addr %h req %0b want 100 1", bus.imem_addr, bus.imem_request); end
        bus.imem_valid = 1'b1;
        tick();
        checks++; if (bus.out_pc !== 32'h100 || bus.out_instr !== instr_of(32'h100) || count !== 3'd1) begin errors++; $display("FAIL flush_first got pc %h instr %h count %0d want 100 %h 1", bus.out_pc, bus.out_instr, count, instr_of(32'h100)); end
        // Flush while a push would otherwise land: the response is dropped.
        flush = 1'b1; redirect_pc = 32'h200;
        tick();
        flush = 1'b0; bus.imem_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL flush_drop got count %0d addr %h want 0 200", count, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        logic [15:0] pat;
        int pushed, popped, mcnt;
        logic push_m, pop_m;
        pat = 16'b1011_0010_0111_0101;
        pushed = 0; popped = 0; mcnt = 0;
        do_reset();
        for (int i = 0; i < 80 && popped < 10; i++) begin
            bus.out_ready  = pat[i % 16];
            bus.imem_valid = (pushed < 10);
            #1;
            push_m = bus.imem_valid && (mcnt < 4);
            pop_m  = bus.out_ready && (mcnt > 0);
            if (pop_m) begin
                checks++; if (bus.out_pc !== 32'(4 * popped) || bus.out_instr !== instr_of(32'(4 * popped))) begin errors++; $display("FAIL wrap_order[%0d] got pc %h instr %h want pc %h", popped, bus.out_pc, bus.out_instr, 32'(4 * popped)); end
                popped++;
            end
            if (push_m) pushed++;
            mcnt = mcnt + int'(push_m) - int'(pop_m);
            tick();
            checks++; if (count !== 3'(mcnt)) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, mcnt); end
        end
        checks++; if (popped != 10) begin errors++; $display("FAIL wrap_done got %0d pops want 10", popped); end
        bus.out_ready = 1'b0; bus.imem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_backpressure();
        test_wait_states();
        test_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue placed between the instruction memory interface and the decode stage. It replaces the single-entry fetch pipeline register with a DEPTH-entry FIFO of {pc, instruction} pairs. It keeps fetching sequentially while space exists, decouples decode stalls from memory latency, and discards all buffered work on a branch/jump redirect.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / instruction address width
- DEPTH, 4, queue entries; power of two, ≥ 2
- INSTR_BYTES, 4, PC increment per fetched instruction
- PC_RESET, 0, first fetch address after reset

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  redirect request (taken branch / jump)
- redirect_pc  in  ADDR_WIDTH  new fetch address, valid when flush=1
- imem_request  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_WIDTH  address of the pending fetch (fetch_pc)
- imem_valid  in  1  instruction memory returns data for the imem_addr of this cycle
- imem_data  in  DATA_WIDTH  returned instruction
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts the head entry
- out_instr  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  head instruction's PC
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation

- State:
  - fetch_pc register
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count register, ranging 0..DEPTH
  - storage array of DEPTH × {ADDR_WIDTH + DATA_WIDTH}
- imem_addr = fetch_pc.
- imem_request = !rst && !flush && (count < DEPTH). The condition uses registered count, so a pop in the same cycle does not open space.
- push = imem_request && imem_valid.
  - Writes {fetch_pc, imem_data} at wr_ptr.
  - Advances wr_ptr.
  - fetch_pc += INSTR_BYTES, truncated to ADDR_WIDTH (wraps at 2^ADDR_WIDTH).
- pop = out_valid && out_ready && !flush. Advances rd_ptr.
- count' = count + push − pop. A simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0). out_instr/out_pc are read combinationally from storage[rd_ptr].
- flush has priority over push and pop in the same cycle:
  - count, wr_ptr and rd_ptr go to 0.
  - fetch_pc is loaded with redirect_pc.
  - imem_data present that cycle is dropped.
  - Storage contents are not cleared.
- Back-to-back fetch: the request stays high across consecutive pushes while count < DEPTH, giving one instruction per cycle with zero-wait memory.
- Memory stalls: imem_addr is held constant while imem_request=1 and imem_valid=0.
- imem_valid while imem_request=0 is ignored.
- out_ready while out_valid=0 is ignored.

## Timing

- Reset (rst high at an edge):
  - count=0, wr_ptr=rd_ptr=0, fetch_pc=PC_RESET.
  - All storage entries are cleared to 0.
  - Hence out_valid=0, out_instr=0, out_pc=0, count=0 after reset.
  - imem_request=0 while rst=1. imem_addr=PC_RESET from the first cycle after reset.
- Reset mid-operation discards all entries. There is no partial state.
- Latency: data pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass from imem_data to out_instr.
- Full: count=DEPTH gives imem_request=0. A pop at edge N re-raises the request in cycle N+1.
- Empty: a pop is impossible. With out_ready=1 and zero-wait memory, steady-state throughput is 1 instruction per cycle.
- Flush at edge N:
  - Cycle N+1 has out_valid=0, count=0, imem_addr=redirect_pc and imem_request=1.
  - The first redirected instruction can reach decode after edge N+1.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0. FIFO order is preserved across the wrap.

## Test plan

- **Reset:** assert rst 2 cycles with PC_RESET=0 → out_valid=0, count=0, imem_request=0. First cycle after reset: imem_request=1, imem_addr=0.
- **Streaming:** zero-wait memory returning instructions 0x00000013, 0x00100093, …, out_ready=1 → out_pc sequence 0,4,8,… in order, one per cycle after a 1-cycle fill latency, count stays ≤ 1.
- **Fill and back-pressure:** out_ready=0, DEPTH=4 → exactly 4 pushes (pc 0,4,8,12), count=4, imem_request=0, imem_addr=16 held. Then a single out_ready pulse → pop pc 0, request re-asserted next cycle, push pc 16.
- **Memory wait states:** imem_valid low 3 cycles per fetch → imem_addr stable during the wait; entries arrive with the correct pc/instr pairing.
- **Flush with full queue and simultaneous imem_valid:** flush=1, redirect_pc=0x100 → the next cycle has count=0, out_valid=0, imem_addr=0x100. The dropped response does not appear, and the first out_pc afterwards is 0x100.
- **Wrap:** DEPTH=4, continuous push/pop of 10 instructions with randomly toggled out_ready → output order matches input order, count never exceeds 4 and never underflows.
